// File: rtl/bitserial_addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: FSM encodings,
// mode constants and the WIDTH/DIGIT configuration check.
package bitserial_addsub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  // DIGIT must tile WIDTH exactly so the last digit lands on the MSB.
  function automatic bit cfg_legal(int width, int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/bitserial_addsub_if.sv
// START/DONE handshake and operand/result bus of the digit-serial add/subtract unit.
interface bitserial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, mode, a, b, borrow_in,
    input  busy, done, result, borrow_out, overflow
  );

  modport slave (
    input  start, mode, a, b, borrow_in,
    output busy, done, result, borrow_out, overflow
  );
endinterface

// File: rtl/bitserial_addsub_digit.sv
// Combinational DIGIT-bit adder/subtractor slice with borrow/carry in and out.
module bitserial_addsub_digit
  import bitserial_addsub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic             mode,
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  logic             cin,
  output logic [DIGIT-1:0] d_dig,
  output logic             cout
);

  logic [DIGIT:0] full;

  // A negative difference wraps into the extra top bit, which is exactly the borrow.
  always_comb begin
    full = '0;
    if (mode == MODE_ADD) begin
      full = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, cin};
    end else begin
      full = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, cin};
    end
  end

  assign d_dig = full[DIGIT-1:0];
  assign cout  = full[DIGIT];

endmodule

// File: rtl/bitserial_addsub.sv
// Digit-serial subtractor/adder: LSB-first, DIGIT bits per clock, START/DONE handshake.
//  state | meaning
//  IDLE  | waiting for START, outputs hold last result
//  RUN   | one digit per cycle through the borrow/carry flop
//  FIN   | DONE pulse, result valid; START here chains the next op
module bitserial_addsub
  import bitserial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  bitserial_addsub_if.slave  bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  if (!cfg_legal(WIDTH, DIGIT)) begin : g_cfg_check
    $error("bitserial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             mode_q, mode_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic [WIDTH-1:0] r_next;
  logic             ovf_next;
  logic             accept;

  bitserial_addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .mode  (mode_q),
    .a_dig (a_sh_q[DIGIT-1:0]),
    .b_dig (b_sh_q[DIGIT-1:0]),
    .cin   (brw_q),
    .d_dig (dig_sum),
    .cout  (dig_cout)
  );

  // New digit enters at the MSB end so after NDIG shifts the word is in place.
  assign r_next = (r_sh_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

  always_comb begin
    ovf_next = 1'b0;
    if (mode_q == MODE_ADD) begin
      ovf_next = (a_msb_q == b_msb_q) && (r_next[WIDTH-1] != a_msb_q);
    end else begin
      ovf_next = (a_msb_q != b_msb_q) && (r_next[WIDTH-1] != a_msb_q);
    end
  end

  assign accept = bus.start && (state_q != ST_RUN);

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    r_sh_d       = r_sh_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    brw_d        = brw_q;
    mode_d       = mode_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    case (state_q)
      ST_RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        r_sh_d = r_next;
        brw_d  = dig_cout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_DIG) begin
          state_d      = ST_FIN;
          result_d     = r_next;
          borrow_out_d = dig_cout;
          overflow_d   = ovf_next;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d = ST_RUN;
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      r_sh_d  = '0;
      brw_d   = bus.borrow_in;
      mode_d  = bus.mode;
      a_msb_d = bus.a[WIDTH-1];
      b_msb_d = bus.b[WIDTH-1];
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      r_sh_q       <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
      brw_q        <= 1'b0;
      mode_q       <= MODE_SUB;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      r_sh_q       <= r_sh_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
      brw_q        <= brw_d;
      mode_q       <= mode_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.busy       = (state_q == ST_RUN);
  assign bus.done       = (state_q == ST_FIN);
  assign bus.result     = result_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_bitserial_addsub.sv
// Bench for bitserial_addsub: DIGIT=1 and DIGIT=4 instances against an arithmetic reference.
module tb_bitserial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start1, start4;
  logic         mode_drv, bin_drv;
  logic [W-1:0] a_drv, b_drv;

  bitserial_addsub_if #(.WIDTH(W)) if1 ();
  bitserial_addsub_if #(.WIDTH(W)) if4 ();

  assign if1.start     = start1;
  assign if1.mode      = mode_drv;
  assign if1.a         = a_drv;
  assign if1.b         = b_drv;
  assign if1.borrow_in = bin_drv;
  assign if4.start     = start4;
  assign if4.mode      = mode_drv;
  assign if4.a         = a_drv;
  assign if4.b         = b_drv;
  assign if4.borrow_in = bin_drv;

  bitserial_addsub #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  bitserial_addsub #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int           lat[2];
  int           ndone[2];
  int           nbusy[2];
  logic [W-1:0] res[2];
  logic         bo[2];
  logic         ov[2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic; overflow from operand and result sign bits.
  function automatic logic [W+1:0] model(logic m, logic [W-1:0] a, logic [W-1:0] b, logic bin);
    logic [W:0] full;
    logic       ovf;
    if (m) full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, bin};
    else   full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    if (m) ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    else   ovf = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  task automatic sample(int k);
    if (if1.busy) nbusy[0]++;
    if (if4.busy) nbusy[1]++;
    if (if1.done) begin
      ndone[0]++;
      if (lat[0] < 0) begin lat[0] = k; res[0] = if1.result; bo[0] = if1.borrow_out; ov[0] = if1.overflow; end
    end
    if (if4.done) begin
      ndone[1]++;
      if (lat[1] < 0) begin lat[1] = k; res[1] = if4.result; bo[1] = if4.borrow_out; ov[1] = if4.overflow; end
    end
  endtask

  // START is driven just after "edge 0"; DONE expected after edge N+1 (N = WIDTH/DIGIT).
  task automatic run_op(string tag, logic m, logic [W-1:0] a, logic [W-1:0] b, logic bin);
    logic [W+1:0] e;
    int           n;
    e = model(m, a, b, bin);
    @(posedge clk); #1;
    mode_drv = m; a_drv = a; b_drv = b; bin_drv = bin;
    start1 = 1'b1; start4 = 1'b1;
    for (int d = 0; d < 2; d++) begin lat[d] = -1; ndone[d] = 0; nbusy[d] = 0; end
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start1 = 1'b0; start4 = 1'b0;
        a_drv = ~a; b_drv = ~b; mode_drv = ~m; bin_drv = ~bin;
      end
      sample(k);
    end
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? W : W / 4;
      chk($sformatf("%s/d%0d/latency", tag, d), lat[d], n + 1);
      chk($sformatf("%s/d%0d/done_count", tag, d), ndone[d], 1);
      chk($sformatf("%s/d%0d/busy_cycles", tag, d), nbusy[d], n);
      chk($sformatf("%s/d%0d/result", tag, d), res[d], e[W-1:0]);
      chk($sformatf("%s/d%0d/borrow_out", tag, d), bo[d], e[W]);
      chk($sformatf("%s/d%0d/overflow", tag, d), ov[d], e[W+1]);
    end
  endtask

  initial begin
    int           de[$];
    logic [W-1:0] dr[$];
    logic [W+1:0] ex, ez;
    int           nd;

    start1 = 1'b0; start4 = 1'b0;
    mode_drv = 1'b0; bin_drv = 1'b0; a_drv = '0; b_drv = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst/busy", if1.busy, 0);
    chk("rst/done", if1.done, 0);
    chk("rst/result", if1.result, 0);
    chk("rst/borrow_out", if1.borrow_out, 0);
    chk("rst/overflow", if1.overflow, 0);
    chk("rst/d4_result", if4.result, 0);
    #20 rst_n = 1'b1;

    run_op("sub_35_12", 1'b0, 8'h35, 8'h12, 1'b0);
    run_op("sub_00_01", 1'b0, 8'h00, 8'h01, 1'b0);
    run_op("sub_80_01", 1'b0, 8'h80, 8'h01, 1'b0);
    run_op("add_7f_01", 1'b1, 8'h7F, 8'h01, 1'b0);
    run_op("add_ff_01", 1'b1, 8'hFF, 8'h01, 1'b0);
    run_op("sub_10_01", 1'b0, 8'h10, 8'h01, 1'b0);
    run_op("sub_bin",   1'b0, 8'h00, 8'h00, 1'b1);
    run_op("add_cin",   1'b1, 8'hFF, 8'hFF, 1'b1);

    // START ignored mid-run, then chained from FIN
    ex = model(1'b0, 8'hA5, 8'h3C, 1'b0);
    ez = model(1'b0, 8'h80, 8'h01, 1'b1);
    @(posedge clk); #1;
    mode_drv = 1'b0; a_drv = 8'hA5; b_drv = 8'h3C; bin_drv = 1'b0; start1 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 4 || k == 10) start1 = 1'b0;
      if (k == 3) begin mode_drv = 1'b1; a_drv = 8'h01; b_drv = 8'h02; bin_drv = 1'b1; start1 = 1'b1; end
      if (k == 10) begin
        chk("b2b/busy_after_fin", if1.busy, 1);
        chk("b2b/done_low", if1.done, 0);
      end
      if (if1.done) begin
        de.push_back(k);
        dr.push_back(if1.result);
        if (de.size() == 1) begin
          mode_drv = 1'b0; a_drv = 8'h80; b_drv = 8'h01; bin_drv = 1'b1; start1 = 1'b1;
        end
      end
    end
    chk("ign/done_pulses", de.size(), 2);
    chk("ign/first_latency", (de.size() > 0) ? de[0] : -1, 9);
    chk("ign/first_result", (dr.size() > 0) ? dr[0] : 8'hxx, ex[W-1:0]);
    chk("b2b/second_latency", (de.size() > 1) ? de[1] : -1, 18);
    chk("b2b/second_result", (dr.size() > 1) ? dr[1] : 8'hxx, ez[W-1:0]);
    chk("b2b/held_result", if1.result, ez[W-1:0]);
    chk("b2b/held_borrow", if1.borrow_out, ez[W]);
    chk("b2b/held_overflow", if1.overflow, ez[W+1]);

    // Reset mid-operation: outputs clear at once and no DONE follows
    run_op("pre_rst", 1'b0, 8'h80, 8'h01, 1'b0);
    @(posedge clk); #1;
    mode_drv = 1'b1; a_drv = 8'h12; b_drv = 8'h34; bin_drv = 1'b0; start1 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
    end
    chk("midrst/busy_before", if1.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst/busy", if1.busy, 0);
    chk("midrst/done", if1.done, 0);
    chk("midrst/result", if1.result, 0);
    chk("midrst/borrow_out", if1.borrow_out, 0);
    chk("midrst/overflow", if1.overflow, 0);
    chk("midrst/d4_result", if4.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (if1.done || if1.busy) nd++;
    end
    chk("midrst/no_activity", nd, 0);

    for (int i = 0; i < 20; i++) begin
      run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
